// File: rtl/cpu_pkg.sv
// Shared SimpleCPU constants: datapath widths, ALU opcodes and the hard-wired zero register.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ALU_OP_WIDTH   = 4;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the decoding instruction.
module hazard_detect #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [ADDR_W-1:0] ex_rd_addr,
  input  logic              uses_rs,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic              uses_rt,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              hazard
);
  import cpu_pkg::*;

  logic rd_live;
  logic rs_hit;
  logic rt_hit;

  always_comb begin
    // r0 is hard-wired, so a load targeting it can never produce a dependency
    rd_live = ex_valid & ex_mem_read & (ex_rd_addr != ADDR_W'(REG_ZERO));
    rs_hit  = uses_rs & (rs_addr == ex_rd_addr);
    rt_hit  = uses_rt & (rt_addr == ex_rd_addr);
    hazard  = rd_live & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/decode_exec_reg.sv
// ID/EX pipeline register: handshake latch with load-use bubble insertion, flush squash
// and writeback refresh of held operands.
module decode_exec_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned ALU_OP_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [DATA_WIDTH-1:0]     dec_pc,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rt_addr,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd_addr,
  input  logic [DATA_WIDTH-1:0]     dec_rs_data,
  input  logic [DATA_WIDTH-1:0]     dec_rt_data,
  input  logic [DATA_WIDTH-1:0]     dec_imm,
  input  logic [ALU_OP_WIDTH-1:0]   dec_alu_op,
  input  logic                      dec_uses_rs,
  input  logic                      dec_uses_rt,
  input  logic                      dec_wb,
  input  logic                      dec_uses_alu,
  input  logic                      dec_mem_read,
  input  logic                      dec_mem_write,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      exec_valid,
  input  logic                      exec_ready,
  output logic [DATA_WIDTH-1:0]     exec_pc,
  output logic [REG_ADDR_WIDTH-1:0] exec_rs_addr,
  output logic [DATA_WIDTH-1:0]     exec_rs_data,
  output logic [REG_ADDR_WIDTH-1:0] exec_rt_addr,
  output logic [DATA_WIDTH-1:0]     exec_rt_data,
  output logic [REG_ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0]     exec_imm,
  output logic [ALU_OP_WIDTH-1:0]   exec_alu_op,
  output logic                      exec_wb,
  output logic                      exec_uses_alu,
  output logic                      exec_mem_read,
  output logic                      exec_mem_write,
  output logic                      load_use_stall,
  output logic [CNT_WIDTH-1:0]      bubble_count
);
  import cpu_pkg::*;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     imm;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic                      wb;
    logic                      uses_alu;
    logic                      mem_read;
    logic                      mem_write;
  } payload_t;

  payload_t             pl_d, pl_q;
  logic                 valid_d, valid_q;
  logic [CNT_WIDTH-1:0] bubble_count_d, bubble_count_q;
  logic                 hazard;
  logic                 advance;
  logic                 dec_load;
  logic                 wb_live;

  hazard_detect #(
    .ADDR_W (REG_ADDR_WIDTH)
  ) u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (pl_q.mem_read),
    .ex_rd_addr  (pl_q.rd_addr),
    .uses_rs     (dec_uses_rs),
    .rs_addr     (dec_rs_addr),
    .uses_rt     (dec_uses_rt),
    .rt_addr     (dec_rt_addr),
    .hazard      (hazard)
  );

  assign advance        = ~valid_q | exec_ready;
  assign dec_ready      = ~rst & (flush | (advance & ~hazard));
  assign load_use_stall = ~rst & hazard & dec_valid & ~flush;
  assign dec_load       = dec_valid & dec_ready & ~flush;
  assign wb_live        = wb_en & (wb_addr != ZERO_ADDR);

  always_comb begin
    valid_d        = valid_q;
    pl_d           = pl_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (dec_load) begin
      valid_d        = 1'b1;
      pl_d.pc        = dec_pc;
      pl_d.rs_addr   = dec_rs_addr;
      pl_d.rs_data   = (wb_live && wb_addr == dec_rs_addr) ? wb_data : dec_rs_data;
      pl_d.rt_addr   = dec_rt_addr;
      pl_d.rt_data   = (wb_live && wb_addr == dec_rt_addr) ? wb_data : dec_rt_data;
      pl_d.rd_addr   = dec_rd_addr;
      pl_d.imm       = dec_imm;
      pl_d.alu_op    = dec_alu_op;
      pl_d.wb        = dec_wb;
      pl_d.uses_alu  = dec_uses_alu;
      pl_d.mem_read  = dec_mem_read;
      pl_d.mem_write = dec_mem_write;
    end else if (load_use_stall && advance) begin
      valid_d = 1'b0;
      if (bubble_count_q != '1) begin
        bubble_count_d = bubble_count_q + CNT_WIDTH'(1);
      end
    end else if (advance) begin
      valid_d = 1'b0;
    end else begin
      // held instruction: keep operands coherent with the register file
      if (wb_live && wb_addr == pl_q.rs_addr) pl_d.rs_data = wb_data;
      if (wb_live && wb_addr == pl_q.rt_addr) pl_d.rt_data = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      pl_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      pl_q           <= pl_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign exec_valid     = valid_q;
  assign exec_pc        = pl_q.pc;
  assign exec_rs_addr   = pl_q.rs_addr;
  assign exec_rs_data   = pl_q.rs_data;
  assign exec_rt_addr   = pl_q.rt_addr;
  assign exec_rt_data   = pl_q.rt_data;
  assign exec_rd_addr   = pl_q.rd_addr;
  assign exec_imm       = pl_q.imm;
  assign exec_alu_op    = pl_q.alu_op;
  assign exec_wb        = pl_q.wb & valid_q;
  assign exec_uses_alu  = pl_q.uses_alu & valid_q;
  assign exec_mem_read  = pl_q.mem_read & valid_q;
  assign exec_mem_write = pl_q.mem_write & valid_q;
  assign bubble_count   = bubble_count_q;

endmodule
